prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 99 +++++++++
 tb/tb_prog_loader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: receives a length-prefixed, XOR-checksummed byte stream, writes 16-bit words to instruction memory, then releases the CPU.
module prog_loader #(
  parameter int ADDR_W = 11,
  parameter int MAX_WORDS = 2048
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_req,
  input  logic              abort,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [15:0]       instr_data_in,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              instr_mem_en_write,
  output logic              cpu_hold,
  output logic              start,
  output logic              busy,
  output logic [1:0]        error_code
);
  typedef enum logic [2:0] {IDLE, HDR_HI, HDR_LO, DATA_HI, DATA_LO, CHK, DONE, ERROR} state_t;
  state_t state, nxt;
  logic [15:0] n, n_new;
  logic [7:0] hi, sum;
  logic [ADDR_W-1:0] idx;
  logic we, accept, take, bad_len, last, match;
  assign accept = byte_valid && byte_ready;
  assign take = accept && !abort;
  assign n_new = {n[15:8], byte_in};
  assign bad_len = n_new == 16'd0 || 32'(n_new) > MAX_WORDS;
  assign last = 32'(idx) == 32'(n) - 32'd1;
  assign match = sum == byte_in;
  // Reset masks a strobe already registered so no write escapes during reset.
  assign instr_mem_en_write = we && !reset;
  always_comb begin
    busy = state != IDLE && state != DONE && state != ERROR;
    byte_ready = busy;
    cpu_hold = state != DONE;
    nxt = state;
    if (!busy) nxt = load_req ? HDR_HI : state;
    else if (abort) nxt = ERROR;
    else if (accept)
      case (state)
        HDR_HI:  nxt = HDR_LO;
        HDR_LO:  nxt = bad_len ? ERROR : DATA_HI;
        DATA_HI: nxt = DATA_LO;
        DATA_LO: nxt = last ? CHK : DATA_HI;
        CHK:     nxt = match ? DONE : ERROR;
        default: nxt = state;
      endcase
  end
  always_ff @(posedge clk) state <= reset ? IDLE : nxt;
  always_ff @(posedge clk) begin
    if (reset) begin
      n <= '0;
      hi <= '0;
      sum <= '0;
      idx <= '0;
      we <= 1'b0;
      start <= 1'b0;
      error_code <= 2'b00;
      instr_data_in <= '0;
      instr_addr <= '0;
    end else begin
      we <= 1'b0;
      start <= 1'b0;
      if (load_req && !busy) begin
        error_code <= 2'b00;
        idx <= '0;
        sum <= '0;
      end
      if (abort && busy) error_code <= 2'b11;
      if (take)
        case (state)
          HDR_HI: n[15:8] <= byte_in;
          HDR_LO: begin
            n[7:0] <= byte_in;
            if (bad_len) error_code <= 2'b01;
          end
          DATA_HI: begin
            hi <= byte_in;
            sum <= sum ^ byte_in;
          end
          DATA_LO: begin
            instr_data_in <= {hi, byte_in};
            instr_addr <= idx;
            we <= 1'b1;
            idx <= idx + 1'b1;
            sum <= sum ^ byte_in;
          end
          CHK: begin
            start <= match;
            if (!match) error_code <= 2'b10;
          end
          default: ;
        endcase
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized stream loads checked against a queue-based model of expected memory writes.
module tb_prog_loader;
  logic clk = 0, reset = 0, load_req = 0, abort = 0, byte_valid = 0;
  logic [7:0] byte_in = 0;
  logic byte_ready, instr_mem_en_write, cpu_hold, start, busy;
  logic [15:0] instr_data_in;
  logic [10:0] instr_addr;
  logic [1:0] error_code;
  int checks = 0, errors = 0, starts = 0;
  logic [10:0] wq_a[$];
  logic [15:0] wq_d[$];

  prog_loader dut (.clk(clk), .reset(reset), .load_req(load_req), .abort(abort), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .instr_data_in(instr_data_in), .instr_addr(instr_addr),
    .instr_mem_en_write(instr_mem_en_write), .cpu_hold(cpu_hold), .start(start), .busy(busy), .error_code(error_code));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (instr_mem_en_write) begin
      wq_a.push_back(instr_addr);
      wq_d.push_back(instr_data_in);
    end
    if (start) starts++;
  end

  function automatic logic [7:0] xsum(input logic [15:0] w[$]);
    logic [7:0] s = 0;
    foreach (w[i]) s ^= w[i][15:8] ^ w[i][7:0];
    return s;
  endfunction

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic clear;
    wq_a.delete();
    wq_d.delete();
    starts = 0;
  endtask

  task automatic pulse_load;
    load_req = 1;
    @(negedge clk);
    load_req = 0;
  endtask

  task automatic send(input logic [7:0] b, input bit gaps);
    int t;
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    byte_in = b;
    byte_valid = 1;
    t = 0;
    while (!byte_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      checks++; errors++;
      $display("FAIL send_timeout: byte_ready=0 after 20 cycles, expected 1");
    end
    @(negedge clk);
    byte_valid = 0;
  endtask

  task automatic send_stream(input logic [15:0] w[$], input logic [7:0] chk, input bit gaps);
    logic [15:0] n;
    n = 16'(w.size());
    send(n[15:8], gaps);
    send(n[7:0], gaps);
    foreach (w[i]) begin
      send(w[i][15:8], gaps);
      send(w[i][7:0], gaps);
    end
    send(chk, gaps);
  endtask

  task automatic test_reset;
    reset = 1; load_req = 1; abort = 1; byte_valid = 1; byte_in = 8'hFF;
    tick(2);
    checks += 9;
    if (cpu_hold !== 1'b1) begin errors++; $display("FAIL rst_cpu_hold: got %b expected 1", cpu_hold); end
    if (start !== 1'b0) begin errors++; $display("FAIL rst_start: got %b expected 0", start); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    if (byte_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", byte_ready); end
    if (instr_mem_en_write !== 1'b0) begin errors++; $display("FAIL rst_we: got %b expected 0", instr_mem_en_write); end
    if (instr_data_in !== 16'h0) begin errors++; $display("FAIL rst_data: got %h expected 0", instr_data_in); end
    if (instr_addr !== 11'h0) begin errors++; $display("FAIL rst_addr: got %h expected 0", instr_addr); end
    if (error_code !== 2'b00) begin errors++; $display("FAIL rst_err: got %b expected 00", error_code); end
    if (starts !== 0) begin errors++; $display("FAIL rst_starts: got %0d expected 0", starts); end
    reset = 0; load_req = 0; abort = 0; byte_valid = 0;
    tick(1);
  endtask

  task automatic test_good;
    clear();
    pulse_load();
    send(8'h00, 0); send(8'h02, 0); send(8'h12, 0);
    pulse_load();
    send(8'h34, 0); send(8'hAB, 0); send(8'hCD, 0); send(8'h40, 0);
    tick(3);
    checks += 9;
    if (wq_a.size() !== 2) begin errors++; $display("FAIL good_nwrites: got %0d expected 2", wq_a.size()); end
    if (wq_a[0] !== 11'd0 || wq_d[0] !== 16'h1234) begin errors++; $display("FAIL good_w0: got %h@%0d expected 1234@0", wq_d[0], wq_a[0]); end
    if (wq_a[1] !== 11'd1 || wq_d[1] !== 16'hABCD) begin errors++; $display("FAIL good_w1: got %h@%0d expected abcd@1", wq_d[1], wq_a[1]); end
    if (starts !== 1) begin errors++; $display("FAIL good_start: got %0d pulses expected 1", starts); end
    if (cpu_hold !== 1'b0) begin errors++; $display("FAIL good_hold: got %b expected 0", cpu_hold); end
    if (error_code !== 2'b00) begin errors++; $display("FAIL good_err: got %b expected 00", error_code); end
    if (busy !== 1'b0) begin errors++; $display("FAIL good_busy: got %b expected 0", busy); end
    if (instr_addr !== 11'd1) begin errors++; $display("FAIL good_hold_addr: got %0d expected 1", instr_addr); end
    if (instr_data_in !== 16'hABCD) begin errors++; $display("FAIL good_hold_data: got %h expected abcd", instr_data_in); end
  endtask

  task automatic test_bad_chk;
    logic [15:0] w[$];
    w = '{16'h1234, 16'hABCD};
    clear();
    pulse_load();
    send_stream(w, xsum(w) ^ 8'h01, 0);
    tick(3);
    checks += 5;
    if (wq_a.size() !== 2) begin errors++; $display("FAIL chk_nwrites: got %0d expected 2", wq_a.size()); end
    if (wq_d[0] !== 16'h1234 || wq_d[1] !== 16'hABCD) begin errors++; $display("FAIL chk_data: got %h %h expected 1234 abcd", wq_d[0], wq_d[1]); end
    if (starts !== 0) begin errors++; $display("FAIL chk_start: got %0d expected 0", starts); end
    if (error_code !== 2'b10) begin errors++; $display("FAIL chk_err: got %b expected 10", error_code); end
    if (cpu_hold !== 1'b1) begin errors++; $display("FAIL chk_hold: got %b expected 1", cpu_hold); end
  endtask

  task automatic test_bad_len;
    logic [15:0] lens[2];
    lens = '{16'd0, 16'd2049};
    foreach (lens[i]) begin
      clear();
      pulse_load();
      send(lens[i][15:8], 0);
      send(lens[i][7:0], 0);
      tick(2);
      checks += 3;
      if (error_code !== 2'b01) begin errors++; $display("FAIL len_err n=%0d: got %b expected 01", lens[i], error_code); end
      if (busy !== 1'b0) begin errors++; $display("FAIL len_busy n=%0d: got %b expected 0", lens[i], busy); end
      if (wq_a.size() !== 0) begin errors++; $display("FAIL len_writes n=%0d: got %0d expected 0", lens[i], wq_a.size()); end
    end
  endtask

  task automatic test_abort;
    logic [15:0] w[$], r[$];
    for (int i = 0; i < 5; i++) w.push_back(16'($urandom));
    clear();
    pulse_load();
    send(8'h00, 1); send(8'h05, 1);
    for (int i = 0; i < 3; i++) begin
      send(w[i][15:8], 1);
      send(w[i][7:0], 1);
    end
    send(w[3][15:8], 1);
    byte_in = w[3][7:0]; byte_valid = 1; abort = 1;
    checks++;
    if (byte_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b expected 1", byte_ready); end
    @(negedge clk);
    byte_valid = 0; abort = 0;
    tick(3);
    checks += 3;
    if (wq_a.size() !== 3) begin errors++; $display("FAIL abort_nwrites: got %0d expected 3", wq_a.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wq_a[i] !== 11'(i) || wq_d[i] !== w[i]) begin errors++; $display("FAIL abort_w%0d: got %h@%0d expected %h@%0d", i, wq_d[i], wq_a[i], w[i], i); end
    end
    if (error_code !== 2'b11) begin errors++; $display("FAIL abort_err: got %b expected 11", error_code); end
    if (starts !== 0) begin errors++; $display("FAIL abort_start: got %0d expected 0", starts); end
    for (int i = 0; i < 2; i++) r.push_back(16'($urandom));
    clear();
    pulse_load();
    send_stream(r, xsum(r), 1);
    tick(3);
    checks += 3;
    if (wq_a.size() !== 2 || wq_a[0] !== 11'd0 || wq_d[0] !== r[0]) begin errors++; $display("FAIL restart_w0: got %h@%0d (n=%0d) expected %h@0 (n=2)", wq_d[0], wq_a[0], wq_a.size(), r[0]); end
    if (starts !== 1) begin errors++; $display("FAIL restart_start: got %0d expected 1", starts); end
    if (error_code !== 2'b00) begin errors++; $display("FAIL restart_err: got %b expected 00", error_code); end
  endtask

  task automatic test_reset_mid;
    clear();
    pulse_load();
    send(8'h00, 0); send(8'h03, 0); send(8'hAA, 0);
    byte_in = 8'hBB; byte_valid = 1;
    @(posedge clk);
    #1 reset = 1; byte_valid = 0;
    @(negedge clk);
    checks++;
    if (instr_mem_en_write !== 1'b0) begin errors++; $display("FAIL rmid_we_now: got %b expected 0", instr_mem_en_write); end
    @(negedge clk);
    checks += 5;
    if (cpu_hold !== 1'b1 || busy !== 1'b0 || byte_ready !== 1'b0) begin errors++; $display("FAIL rmid_ctrl: got hold=%b busy=%b ready=%b expected 1 0 0", cpu_hold, busy, byte_ready); end
    if (instr_data_in !== 16'h0) begin errors++; $display("FAIL rmid_data: got %h expected 0", instr_data_in); end
    if (instr_addr !== 11'h0) begin errors++; $display("FAIL rmid_addr: got %h expected 0", instr_addr); end
    if (error_code !== 2'b00 || start !== 1'b0) begin errors++; $display("FAIL rmid_err: got err=%b start=%b expected 00 0", error_code, start); end
    if (instr_mem_en_write !== 1'b0) begin errors++; $display("FAIL rmid_we: got %b expected 0", instr_mem_en_write); end
    reset = 0;
    tick(3);
    checks++;
    if (wq_a.size() !== 0) begin errors++; $display("FAIL rmid_writes: got %0d expected 0", wq_a.size()); end
  endtask

  task automatic test_full;
    logic [15:0] w[$];
    for (int i = 0; i < 2048; i++) w.push_back(16'($urandom));
    clear();
    pulse_load();
    send_stream(w, xsum(w), 1);
    tick(3);
    checks += 3;
    if (wq_a.size() !== 2048) begin errors++; $display("FAIL full_nwrites: got %0d expected 2048", wq_a.size()); end
    for (int i = 0; i < wq_a.size() && i < 2048; i++) begin
      checks++;
      if (wq_a[i] !== 11'(i) || wq_d[i] !== w[i]) begin errors++; $display("FAIL full_w%0d: got %h@%0d expected %h@%0d", i, wq_d[i], wq_a[i], w[i], i); end
    end
    if (starts !== 1) begin errors++; $display("FAIL full_start: got %0d expected 1", starts); end
    if (error_code !== 2'b00 || cpu_hold !== 1'b0) begin errors++; $display("FAIL full_end: got err=%b hold=%b expected 00 0", error_code, cpu_hold); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_good();
    test_bad_chk();
    test_bad_len();
    test_abort();
    test_reset_mid();
    test_full();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
